// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle sequencer around a combinational MIPS ALU.
// One instruction at a time is taken from fetch. Its operands are latched from
// the register file and presented to the ALU. The instruction then finishes
// with a data-memory access, a register writeback, a branch report or a trap.
//
// Handshakes:
//   instr_valid/instr_ready: a transfer happens on a rising edge where both are
//   high. instr_ready is high only in IDLE. Fetch must hold instr stable while
//   instr_valid is high and not yet accepted.
//   mem_req/mem_ack: mem_req rises when MEM is entered and stays high until the
//   edge on which mem_ack is sampled high. mem_addr, mem_wdata and mem_we stay
//   stable throughout. mem_ack is ignored outside MEM, and mem_rdata is taken
//   with mem_ack.
//
// Every status output is a register that is updated on the state transition.
// The pulses (wb_en, branch_taken, ovf_trap, illegal) are therefore exactly one
// cycle wide.
module mips_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic [31:0] branch_offset,
  output logic        ovf_trap,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out;
  logic [31:0] mdr;

  // Instruction decode fields, all taken from the latched IR
  logic [5:0] op;
  logic [5:0] fn;
  logic       is_rtype;
  logic       rtype_ok;
  logic       is_imm_alu;
  logic       is_lw;
  logic       is_sw;
  logic       is_branch;
  logic       is_legal;
  logic       is_ovf_op;
  logic [4:0] dest;

  assign op       = ir[31:26];
  assign fn       = ir[5:0];
  assign is_rtype = (op == 6'b000000);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_branch = (op == 6'b000100) || (op == 6'b000101);
  // add, sub and addi are the only instructions that trap on overflow
  assign is_ovf_op = (is_rtype && ((fn == 6'b100000) || (fn == 6'b100010)))
                     || (op == 6'b001000);
  assign is_legal = (is_rtype && rtype_ok) || is_imm_alu || is_lw || is_sw || is_branch;
  assign dest     = is_rtype ? ir[15:11] : ir[20:16];

  // Classify the R-type function field and the ALU-immediate opcodes
  always_comb begin
    rtype_ok   = 1'b0;
    is_imm_alu = 1'b0;
    case (fn)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011,
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111: rtype_ok = 1'b1;
      default:                         rtype_ok = 1'b0;
    endcase
    case (op)
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: is_imm_alu = 1'b1;
      default:                         is_imm_alu = 1'b0;
    endcase
  end

  // Datapath views derived directly from the internal registers
  assign rs_addr   = ir[25:21];
  assign rt_addr   = ir[20:16];
  assign alu_instr = ir;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign mem_addr  = alu_out;
  assign mem_wdata = b_q;
  assign wb_addr   = dest;
  assign wb_data   = is_lw ? mdr : alu_out;

  // The less-than flag is consumed by the ALU's own slt result, not here
  logic unused_flags;
  assign unused_flags = alu_flags[1];

  // Sequencer: state, internal registers and all registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ir            <= 32'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      alu_out       <= 32'd0;
      mdr           <= 32'd0;
      instr_ready   <= 1'b1;
      busy          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      wb_en         <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= 32'd0;
      ovf_trap      <= 1'b0;
      illegal       <= 1'b0;
      retired       <= 32'd0;
    end else begin
      // Pulses fall after one cycle unless re-asserted below
      wb_en        <= 1'b0;
      branch_taken <= 1'b0;
      ovf_trap     <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir          <= instr;
            state       <= S_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          a_q <= rs_data;
          b_q <= rt_data;
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            illegal     <= 1'b1;
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        S_EXEC: begin
          alu_out <= alu_result;
          if (is_lw || is_sw) begin
            state   <= S_MEM;
            mem_req <= 1'b1;
            mem_we  <= is_sw;
          end else if (is_branch) begin
            branch_taken  <= alu_flags[0];
            branch_offset <= alu_result;
            retired       <= retired + 32'd1;
            state         <= S_IDLE;
            instr_ready   <= 1'b1;
            busy          <= 1'b0;
          end else if (is_ovf_op && alu_flags[2]) begin
            ovf_trap    <= 1'b1;
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wb_en <= (dest != 5'd0);
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_sw) begin
              retired     <= retired + 32'd1;
              state       <= S_IDLE;
              instr_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              mdr   <= mem_rdata;
              wb_en <= (dest != 5'd0);
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          retired     <= retired + 32'd1;
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule
